lms_ctr_oc_mem_burst: RTL and testbench

Parametrised on-chip memory with an Avalon-MM slave port. It adds pipelined reads (`readdatavalid`), burst reads and writes, `waitrequest` flow control, and a selectable output register. It sits on the `lms_ctr` system interconnect as the burst-capable replacement for the fixed 8K×32 single-port scratch RAM. Memory is inferred: no vendor primitive, no init file, and contents are not cleared by reset.

---
 rtl/lms_ctr_oc_mem_pkg.sv | 22 ++
 rtl/lms_ctr_oc_mem_burst_if.sv | 27 ++
 rtl/lms_ctr_oc_mem_ram.sv | 42 ++++
 rtl/lms_ctr_oc_mem_burst.sv | 148 ++++++++++++++
 tb/tb_lms_ctr_oc_mem_burst.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lms_ctr_oc_mem_pkg.sv
// Shared types and sizing helpers for the lms_ctr burst-capable on-chip memory.
package lms_ctr_oc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_BURST_W = 5;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/lms_ctr_oc_mem_burst_if.sv
// Avalon-MM burst slave bus between the lms_ctr interconnect and the on-chip memory.
interface lms_ctr_oc_mem_burst_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 13,
  parameter int BURST_W = 5
);
  logic                  chipselect;
  logic [ADDR_W-1:0]     address;
  logic                  read;
  logic                  write;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic [BURST_W-1:0]    burstcount;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output chipselect, address, read, write, byteenable, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  chipselect, address, read, write, byteenable, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/lms_ctr_oc_mem_ram.sv
// Inferred single-port byte-enabled RAM with one registered read stage.
module lms_ctr_oc_mem_ram
  import lms_ctr_oc_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                we,
  input  logic                re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);
  localparam int BE_W  = be_w(DATA_W);
  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // byte-lane writes; array contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (ce && we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // read register only moves on an issued read so it holds between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (ce && re) begin
      q <= mem_r[addr];
    end
  end
endmodule

// File: rtl/lms_ctr_oc_mem_burst.sv
// Burst-capable Avalon-MM on-chip memory: command FSM, beat counters and read pipeline.
module lms_ctr_oc_mem_burst
  import lms_ctr_oc_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int OUT_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  input  logic                 reset_req,
  lms_ctr_oc_mem_burst_if.slave bus
);
  localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1'b1);
  localparam logic [ADDR_W-1:0]  ONE_A = ADDR_W'(1'b1);

  state_e              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BURST_W-1:0]  remain_r;
  logic                en_s;
  logic                accept_s;
  logic                wr_s;
  logic                rd_s;
  logic                wait_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_q_s;
  logic                vld1_r;
  logic                vld_out_s;

  assign en_s = clken & ~reset_req;

  // per-state command decode; IDLE addresses the RAM straight from the bus
  always_comb begin
    accept_s   = 1'b0;
    wr_s       = 1'b0;
    rd_s       = 1'b0;
    wait_s     = 1'b1;
    ram_addr_s = addr_r;
    case (state_r)
      IDLE: begin
        accept_s   = bus.chipselect & (bus.read | bus.write) & en_s;
        wr_s       = accept_s & bus.write;
        rd_s       = accept_s & ~bus.write;
        wait_s     = ~en_s;
        ram_addr_s = bus.address;
      end
      RD_BURST: begin
        rd_s   = en_s;
        wait_s = 1'b1;
      end
      WR_BURST: begin
        wr_s   = bus.write & bus.chipselect & en_s;
        wait_s = ~wr_s;
      end
      default: begin
        wait_s = 1'b1;
      end
    endcase
  end

  assign bus.waitrequest = ~reset_n | wait_s;

  // FSM with follow-on beat address and remaining-beat counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      addr_r   <= '0;
      remain_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (bus.burstcount > ONE_B)) begin
            addr_r   <= bus.address + ONE_A;
            remain_r <= bus.burstcount - ONE_B;
            state_r  <= bus.write ? WR_BURST : RD_BURST;
          end
        end
        RD_BURST, WR_BURST: begin
          if (rd_s || wr_s) begin
            addr_r   <= addr_r + ONE_A;
            remain_r <= remain_r - ONE_B;
            if (remain_r == ONE_B) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  lms_ctr_oc_mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (en_s),
    .we      (wr_s),
    .re      (rd_s),
    .be      (bus.byteenable),
    .addr    (ram_addr_s),
    .wdata   (bus.writedata),
    .q       (ram_q_s)
  );

  // first valid stage tracks the RAM read register; frozen while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld1_r <= 1'b0;
    end else if (en_s) begin
      vld1_r <= rd_s;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              vld2_r;
      logic [DATA_W-1:0] dout_r;

      // optional output register adds one cycle of read latency
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld2_r <= 1'b0;
          dout_r <= '0;
        end else if (en_s) begin
          vld2_r <= vld1_r;
          if (vld1_r) begin
            dout_r <= ram_q_s;
          end
        end
      end

      assign vld_out_s    = vld2_r;
      assign bus.readdata = dout_r;
    end else begin : g_noreg
      assign vld_out_s    = vld1_r;
      assign bus.readdata = ram_q_s;
    end
  endgenerate

  // a pending beat is only presented, and consumed, on an enabled cycle
  assign bus.readdatavalid = vld_out_s & en_s;
endmodule

// File: tb/tb_lms_ctr_oc_mem_burst.sv
// Bench for lms_ctr_oc_mem_burst: OUT_REG=0 and OUT_REG=1 instances driven in lockstep.
module tb_lms_ctr_oc_mem_burst;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam int BW = 5;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [3:0]    be;
    logic [DW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b1;
  logic reset_req = 1'b0;
  logic cs = 1'b0;
  logic rd = 1'b0;
  logic wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0] be = 4'h0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] bc = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rnd_on = 1'b0;

  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] wbuf [16];
  int vcnt0 = 0, vcnt1 = 0, first0 = -1, first1 = -1, last0 = -1, last1 = -1;
  logic [DW-1:0] lastd0 = '0, lastd1 = '0;

  lms_ctr_oc_mem_burst_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus0 ();
  lms_ctr_oc_mem_burst_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus1 ();

  assign bus0.chipselect = cs;  assign bus1.chipselect = cs;
  assign bus0.address    = addr; assign bus1.address   = addr;
  assign bus0.read       = rd;  assign bus1.read       = rd;
  assign bus0.write      = wr;  assign bus1.write      = wr;
  assign bus0.byteenable = be;  assign bus1.byteenable = be;
  assign bus0.writedata  = wdata; assign bus1.writedata = wdata;
  assign bus0.burstcount = bc;  assign bus1.burstcount = bc;

  lms_ctr_oc_mem_burst #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .OUT_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .bus(bus0));
  lms_ctr_oc_mem_burst #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .OUT_REG(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
  endfunction

  function automatic void model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] bev);
    logic [DW-1:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (bev[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mem_m[int'(a)] = w;
  endfunction

  // readback monitor: every valid beat must match the next expected word in issue order
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (!(clken && !reset_req)) begin
        chk("stall_rdv0", {31'd0, bus0.readdatavalid}, 32'd0);
        chk("stall_rdv1", {31'd0, bus1.readdatavalid}, 32'd0);
      end
      if (bus0.readdatavalid) begin
        vcnt0++; last0 = cyc; lastd0 = bus0.readdata;
        if (first0 < 0) first0 = cyc;
        if (q0.size() == 0) chk("extra_rdv0", {31'd0, bus0.readdatavalid}, 32'd0);
        else chk("rdata0", bus0.readdata, q0.pop_front());
      end
      if (bus1.readdatavalid) begin
        vcnt1++; last1 = cyc; lastd1 = bus1.readdata;
        if (first1 < 0) first1 = cyc;
        if (q1.size() == 0) chk("extra_rdv1", {31'd0, bus1.readdatavalid}, 32'd0);
        else chk("rdata1", bus1.readdata, q1.pop_front());
      end
    end
  end

  // random clken / reset_req freezes during the randomized phase
  initial forever begin
    @(posedge clk); #1;
    if (rnd_on) begin
      clken = ($urandom_range(0, 3) != 0);
      reset_req = ($urandom_range(0, 7) == 0);
    end
  end

  // caller is at posedge+1; returns at posedge+1 after the last beat was accepted
  task automatic wr_burst(input logic [AW-1:0] a, input logic [BW-1:0] bcv, input logic [3:0] bev, input bit with_rd);
    int n;
    int beat;
    int g;
    n = (bcv == '0) ? 1 : int'(bcv);
    beat = 0; g = 0;
    cs = 1'b1; wr = 1'b1; rd = with_rd; addr = a; bc = bcv; be = bev; wdata = wbuf[0];
    while (beat < n && g < 300) begin
      @(negedge clk);
      if (!bus0.waitrequest) begin
        model_wr(a + AW'(beat), wbuf[beat], bev);
        beat++;
      end
      g++;
      @(posedge clk); #1;
      if (beat < n) wdata = wbuf[beat];
    end
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    if (beat != n) bound_fail("wr_burst_beats");
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [BW-1:0] bcv, output int acc, output int wq_hi);
    int n;
    int g;
    bit done;
    n = (bcv == '0) ? 1 : int'(bcv);
    g = 0; done = 1'b0; acc = -1; wq_hi = 0;
    first0 = -1; first1 = -1;
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a; bc = bcv;
    while (!done && g < 100) begin
      @(negedge clk);
      if (!bus0.waitrequest) begin
        acc = cyc; done = 1'b1;
        for (int i = 0; i < n; i++) begin
          q0.push_back(mem_rd(a + AW'(i)));
          q1.push_back(mem_rd(a + AW'(i)));
        end
      end
      g++;
      @(posedge clk); #1;
    end
    cs = 1'b0; rd = 1'b0;
    if (!done) bound_fail("rd_accept");
    g = 0;
    forever begin
      @(negedge clk);
      if (!bus0.waitrequest || g > 100) break;
      wq_hi++; g++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      bound_fail("rd_drain");
      q0.delete(); q1.delete();
    end
  endtask

  initial begin
    vec_t tbl [5];
    int acc, wh, v0, v1, g, off, n;
    logic [AW-1:0] ra;

    tbl[0] = '{a: 13'h0005, d0: 32'hDEADBEEF, d1: 32'h00000000, be: 4'h0, exp: 32'hDEADBEEF};
    tbl[1] = '{a: 13'h0010, d0: 32'h11223344, d1: 32'hAABBCCDD, be: 4'h5, exp: 32'h11BB33DD};
    tbl[2] = '{a: 13'h0011, d0: 32'h00000000, d1: 32'hFFFFFFFF, be: 4'hA, exp: 32'hFF00FF00};
    tbl[3] = '{a: 13'h1FFF, d0: 32'h12345678, d1: 32'h9ABCDEF0, be: 4'h8, exp: 32'h9A345678};
    tbl[4] = '{a: 13'h0000, d0: 32'hCAFEF00D, d1: 32'h01020304, be: 4'h3, exp: 32'hCAFE0304};

    // reset values while reset_n is low
    #2;
    chk("rst_wait0", {31'd0, bus0.waitrequest}, 32'd1);
    chk("rst_wait1", {31'd0, bus1.waitrequest}, 32'd1);
    chk("rst_rdv0", {31'd0, bus0.readdatavalid}, 32'd0);
    chk("rst_rdv1", {31'd0, bus1.readdatavalid}, 32'd0);
    chk("rst_rdata0", bus0.readdata, 32'd0);
    chk("rst_rdata1", bus1.readdata, 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wait", {31'd0, bus0.waitrequest}, 32'd0);

    // table: full write, byte-enabled overwrite, immediate single read
    for (int i = 0; i < 5; i++) begin
      wbuf[0] = tbl[i].d0; wr_burst(tbl[i].a, 5'd1, 4'hF, 1'b0);
      wbuf[0] = tbl[i].d1; wr_burst(tbl[i].a, 5'd1, tbl[i].be, 1'b0);
      rd_burst(tbl[i].a, 5'd1, acc, wh);
      chk($sformatf("tbl%0d_data0", i), lastd0, tbl[i].exp);
      chk($sformatf("tbl%0d_data1", i), lastd1, tbl[i].exp);
      chk($sformatf("tbl%0d_lat0", i), 32'(first0 - acc), 32'd1);
      chk($sformatf("tbl%0d_lat1", i), 32'(first1 - acc), 32'd2);
    end

    // wrapping write/read burst across the top of the address space
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    wr_burst(13'h1FFE, 5'd4, 4'hF, 1'b0);
    rd_burst(13'h1FFE, 5'd4, acc, wh);
    chk("wrap_wait_hi", 32'(wh), 32'd3);
    chk("wrap_first0", 32'(first0 - acc), 32'd1);
    chk("wrap_last0", 32'(last0 - acc), 32'd4);
    chk("wrap_last1", 32'(last1 - acc), 32'd5);
    chk("wrap_lastdata", lastd0, 32'd4);

    // read+write together with burstcount 0: single write, no read data
    wbuf[0] = 32'h5A5A5A5A;
    v0 = vcnt0; v1 = vcnt1;
    wr_burst(13'h0020, 5'd0, 4'hF, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    chk("rdwr_no_rdv0", 32'(vcnt0 - v0), 32'd0);
    chk("rdwr_no_rdv1", 32'(vcnt1 - v1), 32'd0);
    rd_burst(13'h0020, 5'd0, acc, wh);
    chk("rdwr_data", lastd0, 32'h5A5A5A5A);
    chk("bc0_one_beat", 32'(vcnt0 - v0), 32'd1);

    // window 0x40..0x4F used by later tests
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    wr_burst(13'h0040, 5'd16, 4'hF, 1'b0);

    // 8-beat read with a 3-cycle clken stall in the middle
    v0 = vcnt0; v1 = vcnt1;
    fork
      rd_burst(13'h0040, 5'd8, acc, wh);
      begin
        repeat (3) @(posedge clk);
        #1 clken = 1'b0;
        repeat (3) @(posedge clk);
        #1 clken = 1'b1;
      end
    join
    chk("stall_beats0", 32'(vcnt0 - v0), 32'd8);
    chk("stall_beats1", 32'(vcnt1 - v1), 32'd8);
    chk("stall_last0", 32'(last0 - acc), 32'd11);
    chk("stall_last1", 32'(last1 - acc), 32'd12);

    // reset_n asserted mid-way through a 16-beat read burst
    v0 = vcnt0;
    cs = 1'b1; rd = 1'b1; addr = 13'h0040; bc = 5'd16;
    @(negedge clk);
    chk("rst_burst_accept", {31'd0, bus0.waitrequest}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      q0.push_back(mem_rd(13'h0040 + AW'(i)));
      q1.push_back(mem_rd(13'h0040 + AW'(i)));
    end
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    g = 0;
    while (vcnt0 - v0 < 5 && g < 50) begin @(posedge clk); #1; g++; end
    if (vcnt0 - v0 < 5) bound_fail("rst_burst_beats");
    #2 reset_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("midrst_wait0", {31'd0, bus0.waitrequest}, 32'd1);
    chk("midrst_rdv0", {31'd0, bus0.readdatavalid}, 32'd0);
    chk("midrst_rdv1", {31'd0, bus1.readdatavalid}, 32'd0);
    chk("midrst_rdata0", bus0.readdata, 32'd0);
    chk("midrst_rdata1", bus1.readdata, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle_wait", {31'd0, bus0.waitrequest}, 32'd0);
    v0 = vcnt0; v1 = vcnt1;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_stale0", 32'(vcnt0 - v0), 32'd0);
    chk("midrst_stale1", 32'(vcnt1 - v1), 32'd0);
    rd_burst(13'h0005, 5'd1, acc, wh);
    chk("midrst_ram_kept", lastd0, 32'hDEADBEEF);

    // randomized bursts inside the window with random freezes
    rnd_on = 1'b1;
    for (int t = 0; t < 40; t++) begin
      off = $urandom_range(0, 15);
      n = $urandom_range(0, 16 - off);
      ra = AW'(32'h40 + off);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        wr_burst(ra, BW'(n), 4'($urandom_range(0, 15)), 1'b0);
      end else begin
        rd_burst(ra, BW'(n), acc, wh);
      end
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    clken = 1'b1; reset_req = 1'b0;
    v0 = vcnt0;
    rd_burst(13'h0040, 5'd16, acc, wh);
    chk("final_window_beats", 32'(vcnt0 - v0), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
